// File: rtl/universal_shift_reg_if.sv
// Data/control bundle for universal_shift_reg: mode/data inputs from the driver,
// register contents and serial/status outputs back from the register bank.
interface universal_shift_reg_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin_l;
    logic             sin_r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bar;
    logic             sout_l;
    logic             sout_r;
    logic [CNT_W-1:0] shift_cnt;
    logic             drained;

    modport master (
        output en, mode, d, sin_l, sin_r,
        input  q, q_bar, sout_l, sout_r, shift_cnt, drained
    );

    modport slave (
        input  en, mode, d, sin_l, sin_r,
        output q, q_bar, sout_l, sout_r, shift_cnt, drained
    );
endinterface

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register: hold/load/shift/rotate/preset/invert per cycle,
// with a saturating count of shifts since the last load for parallel-to-serial use.
module usr_bit_cell (
    input  logic [2:0] mode,
    input  logic       cur,
    input  logic       d_bit,
    input  logic       preset_bit,
    input  logic       shl_in,
    input  logic       shr_in,
    input  logic       rol_in,
    input  logic       ror_in,
    output logic       nxt
);
    // Unknown or HOLD mode falls through to keeping the current bit.
    always_comb begin
        nxt = cur;
        case (mode)
            3'b001:  nxt = shl_in;
            3'b010:  nxt = shr_in;
            3'b011:  nxt = rol_in;
            3'b100:  nxt = ror_in;
            3'b101:  nxt = d_bit;
            3'b110:  nxt = preset_bit;
            3'b111:  nxt = ~cur;
            default: nxt = cur;
        endcase
    end
endmodule

module universal_shift_reg #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] PRESET_VALUE = '0
) (
    input logic                 clk,
    input logic                 reset,
    universal_shift_reg_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        M_HOLD   = 3'b000,
        M_SHL    = 3'b001,
        M_SHR    = 3'b010,
        M_ROL    = 3'b011,
        M_ROR    = 3'b100,
        M_LOAD   = 3'b101,
        M_PRESET = 3'b110,
        M_INV    = 3'b111
    } mode_e;

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_inc;
    logic             drained_r;

    // Each bit picks its neighbours; the end bits take the serial inputs for
    // shifts and wrap around for rotates.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        localparam int LO = (i == 0) ? WIDTH - 1 : i - 1;
        localparam int HI = (i == WIDTH - 1) ? 0 : i + 1;
        usr_bit_cell u_cell (
            .mode       (bus.mode),
            .cur        (q_r[i]),
            .d_bit      (bus.d[i]),
            .preset_bit (PRESET_VALUE[i]),
            .shl_in     ((i == 0) ? bus.sin_r : q_r[LO]),
            .shr_in     ((i == WIDTH - 1) ? bus.sin_l : q_r[HI]),
            .rol_in     (q_r[LO]),
            .ror_in     (q_r[HI]),
            .nxt        (q_nxt[i])
        );
    end

    assign cnt_inc = (cnt_r == CNT_W'(WIDTH)) ? cnt_r : cnt_r + CNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_r       <= '0;
            cnt_r     <= '0;
            drained_r <= 1'b0;
        end else if (bus.en) begin
            q_r <= q_nxt;
            case (bus.mode)
                M_LOAD, M_PRESET: begin
                    cnt_r     <= '0;
                    drained_r <= 1'b0;
                end
                M_SHL, M_SHR, M_ROL, M_ROR: begin
                    cnt_r     <= cnt_inc;
                    drained_r <= (cnt_inc == CNT_W'(WIDTH));
                end
                default: ;
            endcase
        end
    end

    assign bus.q         = q_r;
    assign bus.q_bar     = ~q_r;
    assign bus.sout_l    = q_r[WIDTH-1];
    assign bus.sout_r    = q_r[0];
    assign bus.shift_cnt = cnt_r;
    assign bus.drained   = drained_r;
endmodule
